bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one dual-port block RAM between two requesters: m0 is the core data side and m1 is the DMA/debug loader.
- The RAM has a byte-masked synchronous write port (A) and a registered read port (B).
- Each cycle the arbiter grants at most one write on port A and one read on port B, independently.
- Same-type contention is resolved round-robin, one pointer per port. Read data is routed back to the owning requester with a valid strobe.

Parameters:
- ADDR_WIDTH, 14, word address width; must match the RAM instance.
- MAX_WAIT, 15, starvation limit in cycles; width of the per-master wait counters is clog2(MAX_WAIT+1).

Ports:
- clka  in  1  system clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- m0_req  in  1  m0 access request; held until granted.
- m0_we  in  4  byte write mask; 0 = read, nonzero = write.
- m0_addr  in  ADDR_WIDTH  m0 word address.
- m0_wdata  in  32  m0 write data.
- m0_gnt  out  1  combinational; access accepted this cycle.
- m0_rvalid  out  1  registered; read data valid.
- m0_rdata  out  32  read data; meaningful only while m0_rvalid=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0.
- ram_wea  out  4  RAM byte write enables.
- ram_addra  out  ADDR_WIDTH  RAM write address.
- ram_dina  out  32  RAM write data.
- ram_addrb  out  ADDR_WIDTH  RAM read address.
- ram_doutb  in  32  RAM registered read data, valid one cycle after the address is sampled.

Behaviour:
- Classification: a request is a write if req=1 and we!=0; a read if req=1 and we==0.
- Write port:
  - Candidates are the write requesters.
  - One candidate: it wins.
  - Two candidates: wr_ptr picks the winner; wr_ptr then toggles to the loser.
  - Winner drives ram_wea/ram_addra/ram_dina combinationally. With no winner, ram_wea=0.
- Read port:
  - Same scheme using rd_ptr.
  - Winner drives ram_addrb. With no winner, ram_addrb holds its last value.
- Grant: mX_gnt=1 when mX wins either port. A master has only one outstanding request per cycle.
- Mixed requests: if one master reads and the other writes, both are granted in the same cycle.
- Read return:
  - The owner ID is registered with a valid bit.
  - Next cycle the owner's rvalid=1 and its rdata=ram_doutb (passthrough).
  - The non-owner's rvalid=0 and its rdata holds its previous value.
  - Read latency is exactly 1 cycle after gnt; back-to-back reads give rvalid every cycle.
- Starvation override:
  - wait_cnt[X] increments each cycle mX_req=1 and gnt=0, and clears on gnt or when req drops.
  - When wait_cnt[X] reaches MAX_WAIT, X wins its port that cycle regardless of the pointer.
  - If both masters have reached MAX_WAIT, m0 wins.
- Same-cycle collision: a write and a read granted in the same cycle to the same address.
  - Handling is defined under Optional Feature.
  - Any collision stall also increments the read requester's wait_cnt.
- Pointer update: pointers change only on contended grants.
- Reset (async, rst=1): all gnt=0, rvalid=0, rdata=0, ram_wea=0, ram_addra/ram_addrb/ram_dina=0, wr_ptr=rd_ptr=m0, wait counters=0, forwarding registers cleared.
- Reset mid-read: the pending rvalid is dropped and never emitted after reset release.
- Address wrap: none; addresses pass through unchanged.

Optional Feature:
- Macro: BRAM_ARB_FWD_EN.
- Defined (forwarding):
  - A colliding read is granted.
  - The write mask, write data and a collision flag are registered.
  - In the rvalid cycle, each byte with a set mask bit is taken from the registered wdata; the other bytes come from ram_doutb.
  - Zero stall.
- Undefined (stall):
  - A read whose address equals the granted write address in the same cycle is not granted.
  - The read is retried next cycle and then observes the written data.
  - The write is never stalled.

Test Plan:
- Reset then idle -> all outputs 0; no rvalid for 10 cycles. Assert rst mid-read -> rvalid stays 0 through release.
- m0 writes addr 0x10, we=4'hF, data 0xDEADBEEF; next cycle m1 reads 0x10 -> m1_gnt=1; m1_rvalid=1 one cycle later with 0xDEADBEEF.
- m0 and m1 both read continuously, addrs 0x1/0x2 -> grants alternate m0,m1,m0,...; each rvalid lands on the owner with correct data.
- Same cycle: m0 writes 0x20 with we=4'b0011, data 0x0000ABCD over old 0x11223344; m1 reads 0x20:
  - FWD_EN defined -> both granted; m1_rdata=0x1122ABCD.
  - Undefined -> m1_gnt=0 in that cycle, granted next cycle, m1_rdata=0x1122ABCD.
- Starvation, MAX_WAIT=3: force m1 contention via an adversarial test hook so m1 loses repeatedly -> m1 wins no later than its 4th waiting cycle.
- m0 reads while m1 writes, different addrs -> both gnt=1 in the same cycle; RAM ports are driven simultaneously.

Source files
------------

// File: rtl/bram_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter_if
// Requester-side bus of the BRAM port arbiter. One instance per requester.
//   req    : access request, held until gnt
//   we     : byte write mask (0 = read, nonzero = write)
//   addr   : word address
//   wdata  : write data
//   gnt    : access accepted this cycle (combinational)
//   rvalid : read data valid (one cycle after a read gnt)
//   rdata  : read data, meaningful while rvalid=1
// Modports: master (requester side), slave (arbiter side).
// -----------------------------------------------------------------------------
interface bram_port_arbiter_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  req;
  logic [3:0]            we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic                  gnt;
  logic                  rvalid;
  logic [31:0]           rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Shares one dual-port BRAM (port A: byte-masked write, port B: registered
// read) between m0 (core data side) and m1 (DMA/debug loader). Each cycle at
// most one write is granted on port A and one read on port B. Contention on a
// port is resolved round-robin with a per-port pointer, overridden by a
// per-requester starvation counter that saturates at MAX_WAIT.
//
// Optional feature macro: BRAM_ARB_FWD_EN
//   defined   : a read colliding with the same-cycle write is granted and the
//               written bytes are forwarded into the returned data.
//   undefined : the colliding read is held off one cycle and retried.
//
// Ports:
//   clka       : clock, all state on posedge
//   rst        : asynchronous active-high reset
//   m0, m1     : requester buses (bram_port_arbiter_if.slave)
//   ram_wea    : RAM byte write enables
//   ram_addra  : RAM write address
//   ram_dina   : RAM write data
//   ram_addrb  : RAM read address (holds last granted address when idle)
//   ram_doutb  : RAM registered read data
//
// Parameters:
//   ADDR_WIDTH      : word address width
//   MAX_WAIT        : starvation limit in cycles
//   TEST_FREEZE_PTR : test hook; when 1 the round-robin pointers never move,
//                     so the starvation override is the only way m1 can win
// -----------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int ADDR_WIDTH      = 14,
  parameter int MAX_WAIT        = 15,
  parameter bit TEST_FREEZE_PTR = 1'b0
) (
  input  logic                  clka,
  input  logic                  rst,
  bram_port_arbiter_if.slave    m0,
  bram_port_arbiter_if.slave    m1,
  output logic [3:0]            ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [31:0]           ram_dina,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  input  logic [31:0]           ram_doutb
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  // Winner of one port: a lone candidate wins; with two, a starved master
  // wins (m0 first), otherwise the pointer decides. 0 = m0, 1 = m1.
  function automatic logic pick_winner(input logic c0, input logic c1,
                                       input logic s0, input logic s1,
                                       input logic ptr);
    logic w;
    if (c0 && c1) begin
      if (s0) begin
        w = 1'b0;
      end else if (s1) begin
        w = 1'b1;
      end else begin
        w = ptr;
      end
    end else if (c1) begin
      w = 1'b1;
    end else begin
      w = 1'b0;
    end
    return w;
  endfunction

  // Wait counter step: clear on grant or dropped request, else count up
  // and saturate at the limit.
  function automatic logic [WCW-1:0] next_wait(input logic [WCW-1:0] cur,
                                               input logic req,
                                               input logic gnt);
    logic [WCW-1:0] n;
    if (!req || gnt) begin
      n = WCW'(0);
    end else if (cur == WAIT_LIMIT) begin
      n = cur;
    end else begin
      n = cur + WCW'(1);
    end
    return n;
  endfunction

  // Byte-wise merge: masked bytes from wd, the rest from ram.
  function automatic logic [31:0] merge_bytes(input logic [31:0] ram,
                                              input logic [31:0] wd,
                                              input logic [3:0]  mask);
    logic [31:0] o;
    for (int b = 0; b < 4; b++) begin
      o[8*b +: 8] = mask[b] ? wd[8*b +: 8] : ram[8*b +: 8];
    end
    return o;
  endfunction

  logic                  wr_c0_s, wr_c1_s, rd_c0_s, rd_c1_s;
  logic                  starve0_s, starve1_s;
  logic                  wr_win_s, rd_win_s;
  logic                  wr_gnt_s, rd_gnt_s;
  logic [ADDR_WIDTH-1:0] wr_addr_s, rd_addr_s;
  logic                  collide_s;
  logic                  gnt0_s, gnt1_s;
  logic                  rvalid0_s, rvalid1_s;
  logic [31:0]           rd_data_s;

  logic                  wr_ptr_r, rd_ptr_r;
  logic [WCW-1:0]        wait0_r, wait1_r;
  logic                  rd_pend_r, rd_own_r;
  logic [ADDR_WIDTH-1:0] addrb_r;
  logic [31:0]           hold0_r, hold1_r;
`ifdef BRAM_ARB_FWD_EN
  logic                  fwd_hit_r;
  logic [3:0]            fwd_mask_r;
  logic [31:0]           fwd_data_r;
`endif

  // Request classification, port arbitration and collision detection.
  always_comb begin
    wr_c0_s   = m0.req && (m0.we != 4'h0);
    wr_c1_s   = m1.req && (m1.we != 4'h0);
    rd_c0_s   = m0.req && (m0.we == 4'h0);
    rd_c1_s   = m1.req && (m1.we == 4'h0);
    starve0_s = (wait0_r == WAIT_LIMIT);
    starve1_s = (wait1_r == WAIT_LIMIT);
    wr_win_s  = pick_winner(wr_c0_s, wr_c1_s, starve0_s, starve1_s, wr_ptr_r);
    rd_win_s  = pick_winner(rd_c0_s, rd_c1_s, starve0_s, starve1_s, rd_ptr_r);
    wr_addr_s = wr_win_s ? m1.addr : m0.addr;
    rd_addr_s = rd_win_s ? m1.addr : m0.addr;
    // Grants are suppressed while reset is asserted.
    wr_gnt_s  = (wr_c0_s || wr_c1_s) && !rst;
    collide_s = wr_gnt_s && (rd_c0_s || rd_c1_s) && (wr_addr_s == rd_addr_s);
`ifdef BRAM_ARB_FWD_EN
    rd_gnt_s  = (rd_c0_s || rd_c1_s) && !rst;
`else
    // The write always proceeds; a same-address read retries next cycle.
    rd_gnt_s  = (rd_c0_s || rd_c1_s) && !rst && !collide_s;
`endif
  end

  // Grants, RAM port drive and read-return routing.
  always_comb begin
    gnt0_s = (wr_gnt_s && !wr_win_s) || (rd_gnt_s && !rd_win_s);
    gnt1_s = (wr_gnt_s &&  wr_win_s) || (rd_gnt_s &&  rd_win_s);
    m0.gnt = gnt0_s;
    m1.gnt = gnt1_s;
    if (wr_gnt_s) begin
      ram_wea   = wr_win_s ? m1.we    : m0.we;
      ram_addra = wr_addr_s;
      ram_dina  = wr_win_s ? m1.wdata : m0.wdata;
    end else begin
      ram_wea   = 4'h0;
      ram_addra = '0;
      ram_dina  = 32'h0;
    end
    ram_addrb = rd_gnt_s ? rd_addr_s : addrb_r;
`ifdef BRAM_ARB_FWD_EN
    rd_data_s = fwd_hit_r ? merge_bytes(ram_doutb, fwd_data_r, fwd_mask_r) : ram_doutb;
`else
    rd_data_s = ram_doutb;
`endif
    rvalid0_s = rd_pend_r && !rd_own_r;
    rvalid1_s = rd_pend_r &&  rd_own_r;
    m0.rvalid = rvalid0_s;
    m1.rvalid = rvalid1_s;
    // Non-owner keeps showing its last returned word.
    m0.rdata  = rvalid0_s ? rd_data_s : hold0_r;
    m1.rdata  = rvalid1_s ? rd_data_s : hold1_r;
  end

  // Pointers, wait counters, read-owner tracking and data hold registers.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      wr_ptr_r  <= 1'b0;
      rd_ptr_r  <= 1'b0;
      wait0_r   <= WCW'(0);
      wait1_r   <= WCW'(0);
      rd_pend_r <= 1'b0;
      rd_own_r  <= 1'b0;
      addrb_r   <= '0;
      hold0_r   <= 32'h0;
      hold1_r   <= 32'h0;
    end else begin
      // Pointer moves to the loser only when both masters competed.
      if (wr_gnt_s && wr_c0_s && wr_c1_s && !TEST_FREEZE_PTR) begin
        wr_ptr_r <= ~wr_win_s;
      end
      if (rd_gnt_s && rd_c0_s && rd_c1_s && !TEST_FREEZE_PTR) begin
        rd_ptr_r <= ~rd_win_s;
      end
      wait0_r   <= next_wait(wait0_r, m0.req, gnt0_s);
      wait1_r   <= next_wait(wait1_r, m1.req, gnt1_s);
      rd_pend_r <= rd_gnt_s;
      if (rd_gnt_s) begin
        rd_own_r <= rd_win_s;
        addrb_r  <= rd_addr_s;
      end
      if (rvalid0_s) begin
        hold0_r <= rd_data_s;
      end
      if (rvalid1_s) begin
        hold1_r <= rd_data_s;
      end
    end
  end

`ifdef BRAM_ARB_FWD_EN
  // Capture the colliding write so its bytes can override the stale RAM word.
  always_ff @(posedge clka or posedge rst) begin
    if (rst) begin
      fwd_hit_r  <= 1'b0;
      fwd_mask_r <= 4'h0;
      fwd_data_r <= 32'h0;
    end else begin
      fwd_hit_r <= rd_gnt_s && collide_s;
      if (collide_s) begin
        fwd_mask_r <= ram_wea;
        fwd_data_r <= ram_dina;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed bench with a read-first behavioural BRAM. Expected read data is
// pushed into per-master queues when the read is issued; a monitor pops and
// compares whenever a master's rvalid is seen. A second instance with
// MAX_WAIT=3 and frozen pointers exercises the starvation override.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;
  localparam int AW = 14;

  logic clka = 1'b0;
  logic rst;
  always #5 clka = ~clka;

  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) m0_if ();
  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) m1_if ();
  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) s0_if ();
  bram_port_arbiter_if #(.ADDR_WIDTH(AW)) s1_if ();

  logic [3:0]    ram_wea,   s_ram_wea;
  logic [AW-1:0] ram_addra, s_ram_addra;
  logic [31:0]   ram_dina,  s_ram_dina;
  logic [AW-1:0] ram_addrb, s_ram_addrb;
  logic [31:0]   ram_doutb, s_ram_doutb;

  assign s_ram_doutb = 32'h0;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(15)) dut (
    .clka(clka), .rst(rst), .m0(m0_if), .m1(m1_if),
    .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb)
  );

  bram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_WAIT(3), .TEST_FREEZE_PTR(1'b1)) dut_starve (
    .clka(clka), .rst(rst), .m0(s0_if), .m1(s1_if),
    .ram_wea(s_ram_wea), .ram_addra(s_ram_addra), .ram_dina(s_ram_dina),
    .ram_addrb(s_ram_addrb), .ram_doutb(s_ram_doutb)
  );

  // Read-first BRAM model: byte-masked write, registered read of old contents.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clka) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wea[b]) mem[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
    end
    ram_doutb <= mem[ram_addrb];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp0_q[$];
  logic [31:0] exp1_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_m(input int id, input logic req, input logic [3:0] we,
                       input logic [AW-1:0] addr, input logic [31:0] wd);
    if (id == 0) begin
      m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wd;
    end else if (id == 1) begin
      m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wd;
    end else if (id == 2) begin
      s0_if.req = req; s0_if.we = we; s0_if.addr = addr; s0_if.wdata = wd;
    end else begin
      s1_if.req = req; s1_if.we = we; s1_if.addr = addr; s1_if.wdata = wd;
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) set_m(i, 1'b0, 4'h0, '0, 32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clka);
    #1;
  endtask

  // Scoreboard monitor: every rvalid must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clka);
      if (m0_if.rvalid) begin
        if (exp0_q.size() == 0) check("m0_unexpected_rvalid", 32'd1, 32'd0);
        else check("m0_rdata", m0_if.rdata, exp0_q.pop_front());
      end
      if (m1_if.rvalid) begin
        if (exp1_q.size() == 0) check("m1_unexpected_rvalid", 32'd1, 32'd0);
        else check("m1_rdata", m1_if.rdata, exp1_q.pop_front());
      end
    end
  end

  initial begin
    logic exp_m0;
    rst = 1'b1;
    idle_all();
    // Reset: a pending write request must not be granted or reach the RAM.
    set_m(0, 1'b1, 4'hF, 14'h5, 32'h12345678);
    @(negedge clka);
    check("rst_m0_gnt", {31'd0, m0_if.gnt}, 32'd0);
    check("rst_m1_gnt", {31'd0, m1_if.gnt}, 32'd0);
    check("rst_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
    check("rst_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd0);
    check("rst_m0_rdata", m0_if.rdata, 32'h0);
    check("rst_m1_rdata", m1_if.rdata, 32'h0);
    check("rst_ram_wea", {28'd0, ram_wea}, 32'd0);
    check("rst_ram_addra", {18'd0, ram_addra}, 32'd0);
    check("rst_ram_addrb", {18'd0, ram_addrb}, 32'd0);
    check("rst_ram_dina", ram_dina, 32'h0);
    idle_all();
    next_cycle();
    rst = 1'b0;

    // Idle for 10 cycles: no rvalid at all.
    for (int i = 0; i < 10; i++) begin
      @(negedge clka);
      check("idle_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
      check("idle_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd0);
      next_cycle();
    end

    // m0 writes 0x10, then m1 reads it back.
    set_m(0, 1'b1, 4'hF, 14'h10, 32'hDEADBEEF);
    @(negedge clka);
    check("wr_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    check("wr_m1_gnt", {31'd0, m1_if.gnt}, 32'd0);
    check("wr_ram_wea", {28'd0, ram_wea}, 32'hF);
    check("wr_ram_addra", {18'd0, ram_addra}, 32'h10);
    check("wr_ram_dina", ram_dina, 32'hDEADBEEF);
    next_cycle();
    set_m(0, 1'b0, 4'h0, '0, 32'h0);
    set_m(1, 1'b1, 4'h0, 14'h10, 32'h0);
    exp1_q.push_back(32'hDEADBEEF);
    @(negedge clka);
    check("rd_m1_gnt", {31'd0, m1_if.gnt}, 32'd1);
    check("rd_ram_addrb", {18'd0, ram_addrb}, 32'h10);
    next_cycle();
    idle_all();
    @(negedge clka);
    check("rd_m1_rvalid_lat1", {31'd0, m1_if.rvalid}, 32'd1);
    next_cycle();

    // Contended writes: pointer starts at m0, so m0 then m1.
    set_m(0, 1'b1, 4'hF, 14'h1, 32'hA0A00001);
    set_m(1, 1'b1, 4'hF, 14'h2, 32'hB0B00002);
    @(negedge clka);
    check("wcont_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    check("wcont_m1_gnt", {31'd0, m1_if.gnt}, 32'd0);
    check("wcont_addra0", {18'd0, ram_addra}, 32'h1);
    next_cycle();
    set_m(0, 1'b0, 4'h0, '0, 32'h0);
    @(negedge clka);
    check("wcont_m1_gnt2", {31'd0, m1_if.gnt}, 32'd1);
    check("wcont_addra1", {18'd0, ram_addra}, 32'h2);
    next_cycle();

    // Continuous reads from both: grants alternate m0, m1, m0, ...
    set_m(0, 1'b1, 4'h0, 14'h1, 32'h0);
    set_m(1, 1'b1, 4'h0, 14'h2, 32'h0);
    for (int i = 0; i < 6; i++) begin
      exp_m0 = ((i % 2) == 0);
      if (exp_m0) exp0_q.push_back(32'hA0A00001);
      else        exp1_q.push_back(32'hB0B00002);
      @(negedge clka);
      check("rr_m0_gnt", {31'd0, m0_if.gnt}, {31'd0, exp_m0});
      check("rr_m1_gnt", {31'd0, m1_if.gnt}, {31'd0, !exp_m0});
      check("rr_addrb", {18'd0, ram_addrb}, exp_m0 ? 32'h1 : 32'h2);
      next_cycle();
    end
    idle_all();
    next_cycle();

    // Collision: partial write over 0x11223344 and same-cycle read.
    set_m(1, 1'b1, 4'hF, 14'h20, 32'h11223344);
    next_cycle();
    set_m(0, 1'b1, 4'b0011, 14'h20, 32'h0000ABCD);
    set_m(1, 1'b1, 4'h0, 14'h20, 32'h0);
    exp1_q.push_back(32'h1122ABCD);
    @(negedge clka);
    check("col_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
`ifdef BRAM_ARB_FWD_EN
    check("col_m1_gnt_fwd", {31'd0, m1_if.gnt}, 32'd1);
    next_cycle();
    idle_all();
`else
    check("col_m1_gnt_stall", {31'd0, m1_if.gnt}, 32'd0);
    next_cycle();
    set_m(0, 1'b0, 4'h0, '0, 32'h0);
    @(negedge clka);
    check("col_m1_gnt_retry", {31'd0, m1_if.gnt}, 32'd1);
    next_cycle();
    idle_all();
`endif
    next_cycle();

    // Mixed: m0 reads while m1 writes elsewhere; both ports driven.
    set_m(0, 1'b1, 4'h0, 14'h10, 32'h0);
    set_m(1, 1'b1, 4'hF, 14'h30, 32'h55AA55AA);
    exp0_q.push_back(32'hDEADBEEF);
    @(negedge clka);
    check("mix_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    check("mix_m1_gnt", {31'd0, m1_if.gnt}, 32'd1);
    check("mix_addrb", {18'd0, ram_addrb}, 32'h10);
    check("mix_wea", {28'd0, ram_wea}, 32'hF);
    check("mix_addra", {18'd0, ram_addra}, 32'h30);
    check("mix_dina", ram_dina, 32'h55AA55AA);
    next_cycle();
    idle_all();
    next_cycle();

    // Reset mid-read: the granted read's rvalid must never appear.
    set_m(0, 1'b1, 4'h0, 14'h1, 32'h0);
    @(negedge clka);
    check("rstrd_m0_gnt", {31'd0, m0_if.gnt}, 32'd1);
    @(posedge clka);
    rst = 1'b1;
    idle_all();
    #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clka);
      check("rstrd_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
      next_cycle();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clka);
      check("rstrel_m0_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
      check("rstrel_m0_rdata", m0_if.rdata, 32'h0);
      next_cycle();
    end

    // Starvation: pointers frozen at m0, MAX_WAIT=3 -> m1 wins on 4th cycle.
    set_m(2, 1'b1, 4'h0, 14'h3, 32'h0);
    set_m(3, 1'b1, 4'h0, 14'h4, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clka);
      check("starve_m1_gnt", {31'd0, s1_if.gnt}, (k == 4) ? 32'd1 : 32'd0);
      check("starve_m0_gnt", {31'd0, s0_if.gnt}, (k == 4) ? 32'd0 : 32'd1);
      next_cycle();
    end
    idle_all();
    next_cycle();
    next_cycle();

    check("sb_m0_drained", exp0_q.size(), 32'd0);
    check("sb_m1_drained", exp1_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
